alu_word_seq: RTL and testbench
===============================

Name: alu_word_seq

Overview:
- Byte-serial, multi-byte successor to the single-byte Z8 ALU.
- Performs one arithmetic, logic or shift/rotate operation on a WORD of BYTES bytes, one byte per clock, with carry/bit chaining between bytes.
- Produces Z8-format flags for the whole word.
- Sits beside the byte ALU in the execute stage; used for word ops (INCW/DECW, 16/32-bit adds, long rotates) without microcode byte sequencing.

Parameters:
- BYTES, 2, number of bytes per word (legal 1..8); W = 8*BYTES.
- FLAG_C_BIT, 7, carry bit index in the flag byte (Z=6, S=5, V=4, D=3, H=2 fixed relative to Z8 layout).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when busy=0
- mode  in  4  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 CP, 5 AND, 6 OR, 7 XOR, 8 INC, 9 DEC, A COM, B RL, C RLC, D RR, E RRC, F SRA
- a  in  W  operand A (INC/DEC/COM/shift source)
- b  in  W  operand B
- flags_in  in  8  incoming flag byte (C for ADC/SBC/RLC/RRC, D for CP, unchanged bits)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- out  out  W  result word, held until next done
- out_flags  out  8  result flags, held until next done

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, out=0, out_flags=0. Reset during RUN aborts with no done pulse and no result update; reset wins over a simultaneous start.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - start=1 in IDLE or DONE latches mode/a/b/flags_in and enters RUN at the next edge.
  - start during RUN is ignored (not queued).
- RUN lasts exactly BYTES cycles with busy=1 and byte index i from 0 to BYTES-1.
  - LSB-first for ADD..DEC, COM, RL, RLC; MSB-first for RR, RRC, SRA.
  - Partial result accumulates in an internal register; out is not updated mid-operation.
- DONE: the cycle after the last byte, out/out_flags update, done=1 and busy=0 for exactly one cycle.
  - Latency from start sample to done = BYTES+1 cycles.
  - Back-to-back: start during DONE is accepted, giving throughput of one op per BYTES+1 cycles.
- Carry chain:
  - Byte 0 carry-in: ADD=0, ADC=flags_in.C, SUB/CP=0 borrow, SBC=flags_in.C borrow, INC=1, DEC=1 borrow.
  - Each later byte uses the previous byte's carry/borrow out; the final carry is C.
- Shift chain:
  - Bit shifted out of one byte becomes the bit shifted into the next.
  - End-in bit: RL=a[W-1], RLC=flags_in.C, RR=a[0], RRC=flags_in.C, SRA=a[W-1].
  - C = last bit shifted out.
- Flags, word-wide:
  - Z = all result bytes zero. S = out[W-1].
  - V: add/sub/INC/DEC = signed overflow of the top byte; logic/COM = 0; shifts = a[W-1] XOR out[W-1].
  - H = half-carry of the top byte for ADD/ADC/SUB/SBC/CP, unchanged otherwise.
  - D = 0 for ADD/ADC, 1 for SUB/SBC, unchanged otherwise.
  - C unchanged for logic, COM, INC and DEC.
  - Bits 1:0 pass through from flags_in.
- CP: out = a (operand unchanged); flags as SUB, but D unchanged.
- BYTES=1 must match byte-ALU results and flags for all supported modes.

Test Plan:
- BYTES=2, ADD a=0x00FF b=0x0001 -> done exactly 3 cycles after start; out=0x0100, C=0, Z=0, S=0, V=0, H=0, D=0.
- BYTES=2, SBC a=0x0000 b=0x0000 flags_in.C=1 -> out=0xFFFF, C=1, S=1, Z=0, D=1; then DEC a=0x8000 -> out=0x7FFF, V=1, C unchanged.
- BYTES=4, RRC a=0x00000001 flags_in.C=1 -> out=0x80000000, C=1, S=1, V=1; then RL a=0x80000000 -> out=0x00000001, C=1.
- BYTES=2, CP a=0x1234 b=0x1234 flags_in.D=0 -> out=0x1234, Z=1, C=0, D=0; start pulsed during busy is ignored, and start asserted in the DONE cycle is accepted (done again after 3 cycles).
- Reset asserted in 2nd RUN cycle of ADD 0xFFFF+0x0001 -> next cycle busy=0, done never pulses, out=0, out_flags=0.
- BYTES=1 sweep of all 16 modes over random a/b/flags_in -> matches byte-ALU model bit-exact for out and out_flags.

Source files
------------

// File: rtl/alu_word_seq.sv
// Byte-serial word ALU: one byte per clock with carry/shift chaining, Z8-format flags for the word.
// Latency BYTES+1 cycles from the start sample to done; no backpressure, a start while busy is dropped.
module alu_word_seq #(
    parameter int BYTES      = 2,
    parameter int FLAG_C_BIT = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           mode,
    input  logic [8*BYTES-1:0]   a,
    input  logic [8*BYTES-1:0]   b,
    input  logic [7:0]           flags_in,
    output logic                 busy,
    output logic                 done,
    output logic [8*BYTES-1:0]   out,
    output logic [7:0]           out_flags
);

    localparam int W  = 8 * BYTES;
    localparam int FZ = 6;
    localparam int FS = 5;
    localparam int FV = 4;
    localparam int FD = 3;
    localparam int FH = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
        OP_CP  = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_INC = 4'h8, OP_DEC = 4'h9, OP_COM = 4'hA, OP_RL  = 4'hB,
        OP_RLC = 4'hC, OP_RR  = 4'hD, OP_RRC = 4'hE, OP_SRA = 4'hF
    } op_t;

    state_t         r_state;
    op_t            r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [7:0]     r_flags;
    logic [W-1:0]   r_acc;
    logic           r_chain;
    logic [2:0]     r_idx;

    logic           w_msb_first;
    logic           w_last;
    logic [2:0]     w_pos;
    logic [7:0]     w_x;
    logic [7:0]     w_y;
    logic [8:0]     w_sum9;
    logic [4:0]     w_nib5;
    logic [7:0]     w_res_b;
    logic           w_co;
    logic           w_h;
    logic           w_v;
    logic [W-1:0]   w_acc_nxt;
    logic [W-1:0]   w_out_nxt;
    logic [7:0]     w_flags_nxt;

    // Chain seed for byte 0: carry/borrow-in for arithmetic, end-in bit for shifts.
    function automatic logic chain_init(input op_t op, input logic [W-1:0] av, input logic fc);
        logic c;
        case (op)
            OP_ADC, OP_SBC, OP_RLC, OP_RRC: c = fc;
            OP_INC, OP_DEC:                 c = 1'b1;
            OP_RL, OP_SRA:                  c = av[W-1];
            OP_RR:                          c = av[0];
            default:                        c = 1'b0;
        endcase
        return c;
    endfunction

    assign w_msb_first = (r_op == OP_RR) || (r_op == OP_RRC) || (r_op == OP_SRA);
    assign w_last      = (r_idx == 3'(BYTES - 1));
    assign w_pos       = w_msb_first ? (3'(BYTES - 1) - r_idx) : r_idx;

    always_comb begin : byte_sel
        w_x = 8'h00;
        w_y = 8'h00;
        for (int k = 0; k < BYTES; k++) begin
            if (w_pos == 3'(k)) begin
                w_x = r_a[8*k +: 8];
                w_y = r_b[8*k +: 8];
            end
        end
        if ((r_op == OP_INC) || (r_op == OP_DEC)) begin
            w_y = 8'h00;
        end
    end

    always_comb begin : byte_alu
        w_sum9  = 9'd0;
        w_nib5  = 5'd0;
        w_res_b = 8'h00;
        w_co    = r_chain;
        w_h     = 1'b0;
        w_v     = 1'b0;
        case (r_op)
            OP_ADD, OP_ADC, OP_INC: begin
                w_sum9  = {1'b0, w_x} + {1'b0, w_y} + {8'd0, r_chain};
                w_nib5  = {1'b0, w_x[3:0]} + {1'b0, w_y[3:0]} + {4'd0, r_chain};
                w_res_b = w_sum9[7:0];
                w_co    = w_sum9[8];
                w_h     = w_nib5[4];
                w_v     = (w_x[7] == w_y[7]) && (w_sum9[7] != w_x[7]);
            end
            OP_SUB, OP_SBC, OP_CP, OP_DEC: begin
                // Bit 8 / bit 4 of the wrapped difference are the byte and nibble borrows.
                w_sum9  = {1'b0, w_x} - {1'b0, w_y} - {8'd0, r_chain};
                w_nib5  = {1'b0, w_x[3:0]} - {1'b0, w_y[3:0]} - {4'd0, r_chain};
                w_res_b = w_sum9[7:0];
                w_co    = w_sum9[8];
                w_h     = w_nib5[4];
                w_v     = (w_x[7] != w_y[7]) && (w_sum9[7] != w_x[7]);
            end
            OP_AND: w_res_b = w_x & w_y;
            OP_OR:  w_res_b = w_x | w_y;
            OP_XOR: w_res_b = w_x ^ w_y;
            OP_COM: w_res_b = ~w_x;
            OP_RL, OP_RLC: begin
                w_res_b = {w_x[6:0], r_chain};
                w_co    = w_x[7];
            end
            OP_RR, OP_RRC, OP_SRA: begin
                w_res_b = {r_chain, w_x[7:1]};
                w_co    = w_x[0];
            end
            default: ;
        endcase
    end

    always_comb begin : acc_merge
        w_acc_nxt = r_acc;
        for (int k = 0; k < BYTES; k++) begin
            if (w_pos == 3'(k)) begin
                w_acc_nxt[8*k +: 8] = w_res_b;
            end
        end
    end

    // Only consumed on the last byte; arithmetic runs LSB-first so w_h/w_v belong to the top byte.
    always_comb begin : flag_calc
        w_out_nxt       = (r_op == OP_CP) ? r_a : w_acc_nxt;
        w_flags_nxt     = r_flags;
        w_flags_nxt[FZ] = (w_acc_nxt == '0);
        w_flags_nxt[FS] = w_acc_nxt[W-1];
        case (r_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
                w_flags_nxt[FLAG_C_BIT] = w_co;
                w_flags_nxt[FV]         = w_v;
                w_flags_nxt[FH]         = w_h;
                if (r_op != OP_CP) begin
                    w_flags_nxt[FD] = (r_op == OP_SUB) || (r_op == OP_SBC);
                end
            end
            OP_INC, OP_DEC: w_flags_nxt[FV] = w_v;
            OP_AND, OP_OR, OP_XOR, OP_COM: w_flags_nxt[FV] = 1'b0;
            default: begin
                w_flags_nxt[FLAG_C_BIT] = w_co;
                w_flags_nxt[FV]         = r_a[W-1] ^ w_acc_nxt[W-1];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ADD;
            r_a       <= '0;
            r_b       <= '0;
            r_flags   <= 8'h00;
            r_acc     <= '0;
            r_chain   <= 1'b0;
            r_idx     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            out_flags <= 8'h00;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op    <= op_t'(mode);
                        r_a     <= a;
                        r_b     <= b;
                        r_flags <= flags_in;
                        r_chain <= chain_init(op_t'(mode), a, flags_in[FLAG_C_BIT]);
                        r_idx   <= 3'd0;
                        r_state <= S_RUN;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_chain <= w_co;
                    if (w_last) begin
                        r_state   <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        out       <= w_out_nxt;
                        out_flags <= w_flags_nxt;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_word_seq.sv
// Bench for alu_word_seq: BYTES=1/2/4 instances, directed vector table, hand sequences, random vs word-level model.
module tb_alu_word_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        st1, st2, st4;
    logic [3:0]  md1, md2, md4;
    logic [7:0]  a1, b1, f1, f2, f4;
    logic [15:0] a2, b2;
    logic [31:0] a4, b4;
    logic        bz1, bz2, bz4, dn1, dn2, dn4;
    logic [7:0]  o1, of1, of2, of4;
    logic [15:0] o2;
    logic [31:0] o4;

    alu_word_seq #(.BYTES(1), .FLAG_C_BIT(7)) u_dut1 (
        .clk(clk), .reset(reset), .start(st1), .mode(md1), .a(a1), .b(b1), .flags_in(f1),
        .busy(bz1), .done(dn1), .out(o1), .out_flags(of1));
    alu_word_seq #(.BYTES(2), .FLAG_C_BIT(7)) u_dut2 (
        .clk(clk), .reset(reset), .start(st2), .mode(md2), .a(a2), .b(b2), .flags_in(f2),
        .busy(bz2), .done(dn2), .out(o2), .out_flags(of2));
    alu_word_seq #(.BYTES(4), .FLAG_C_BIT(7)) u_dut4 (
        .clk(clk), .reset(reset), .start(st4), .mode(md4), .a(a4), .b(b4), .flags_in(f4),
        .busy(bz4), .done(dn4), .out(o4), .out_flags(of4));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Word-level reference: whole-word arithmetic, half carry/borrow taken at bit W-4.
    function automatic void model(input int nb, input logic [3:0] m, input logic [63:0] a_in,
                                  input logic [63:0] b_in, input logic [7:0] f,
                                  output logic [63:0] r_out, output logic [7:0] f_out);
        int w;
        logic [64:0] mask, m4, av, bv, bb, res, hs;
        logic cin, fc;
        w     = 8 * nb;
        mask  = (65'd1 << w) - 65'd1;
        m4    = (65'd1 << (w - 4)) - 65'd1;
        av    = {1'b0, a_in} & mask;
        bv    = {1'b0, b_in} & mask;
        fc    = f[7];
        f_out = f;
        res   = '0;
        case (m)
            4'h0, 4'h1, 4'h8: begin
                cin = (m == 4'h1) ? fc : (m == 4'h8);
                bb  = (m == 4'h8) ? 65'd0 : bv;
                res = av + bb + 65'(cin);
                hs  = (av & m4) + (bb & m4) + 65'(cin);
                f_out[4] = (av[w-1] == bb[w-1]) && (res[w-1] != av[w-1]);
                if (m != 4'h8) begin
                    f_out[7] = res[w];
                    f_out[2] = hs[w-4];
                    f_out[3] = 1'b0;
                end
            end
            4'h2, 4'h3, 4'h4, 4'h9: begin
                cin = (m == 4'h3) ? fc : (m == 4'h9);
                bb  = (m == 4'h9) ? 65'd0 : bv;
                res = (av - bb - 65'(cin)) & mask;
                f_out[4] = (av[w-1] != bb[w-1]) && (res[w-1] != av[w-1]);
                if (m != 4'h9) begin
                    f_out[7] = (av < bb + 65'(cin));
                    f_out[2] = ((av & m4) < (bb & m4) + 65'(cin));
                    if (m != 4'h4) f_out[3] = 1'b1;
                end
            end
            4'h5: res = av & bv;
            4'h6: res = av | bv;
            4'h7: res = av ^ bv;
            4'hA: res = ~av & mask;
            4'hB: begin res = ((av << 1) | 65'(av[w-1])) & mask; f_out[7] = av[w-1]; end
            4'hC: begin res = ((av << 1) | 65'(fc)) & mask;      f_out[7] = av[w-1]; end
            4'hD: begin res = (av >> 1) | (65'(av[0]) << (w - 1)); f_out[7] = av[0]; end
            4'hE: begin res = (av >> 1) | (65'(fc) << (w - 1));    f_out[7] = av[0]; end
            default: begin res = (av >> 1) | (65'(av[w-1]) << (w - 1)); f_out[7] = av[0]; end
        endcase
        res &= mask;
        if (m inside {4'h5, 4'h6, 4'h7, 4'hA}) f_out[4] = 1'b0;
        if (m >= 4'hB) f_out[4] = av[w-1] ^ res[w-1];
        f_out[6] = (res == 65'd0);
        f_out[5] = res[w-1];
        r_out = (m == 4'h4) ? av[63:0] : res[63:0];
    endfunction

    // Same operation on all three instances; checks each finishes exactly BYTES+1 cycles after start.
    task automatic run_op(input logic [3:0] m, input logic [63:0] av, input logic [63:0] bv,
                          input logic [7:0] f);
        int lat1, lat2, lat4;
        @(posedge clk); #1;
        md1 = m; md2 = m; md4 = m;
        a1 = av[7:0]; a2 = av[15:0]; a4 = av[31:0];
        b1 = bv[7:0]; b2 = bv[15:0]; b4 = bv[31:0];
        f1 = f; f2 = f; f4 = f;
        st1 = 1'b1; st2 = 1'b1; st4 = 1'b1;
        lat1 = 0; lat2 = 0; lat4 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin st1 = 1'b0; st2 = 1'b0; st4 = 1'b0; end
            if (dn1 && lat1 == 0) lat1 = c;
            if (dn2 && lat2 == 0) lat2 = c;
            if (dn4 && lat4 == 0) lat4 = c;
        end
        chk("latency_b1", 64'(lat1), 64'd2);
        chk("latency_b2", 64'(lat2), 64'd3);
        chk("latency_b4", 64'(lat4), 64'd5);
    endtask

    typedef struct {
        int          nb;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  f;
        logic [31:0] eo;
        logic [7:0]  ef;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl[NV];

    initial begin
        logic [63:0] got_o, exp_o, av, bv;
        logic [7:0]  got_f, exp_f, fv;
        logic [3:0]  mv;
        logic        saw;

        tbl[0]  = '{2, 4'h0, 32'h0000_00FF, 32'h0000_0001, 8'h03, 32'h0000_0100, 8'h03};
        tbl[1]  = '{2, 4'h3, 32'h0000_0000, 32'h0000_0000, 8'h80, 32'h0000_FFFF, 8'hAC};
        tbl[2]  = '{2, 4'h9, 32'h0000_8000, 32'h0000_0000, 8'h80, 32'h0000_7FFF, 8'h90};
        tbl[3]  = '{4, 4'hE, 32'h0000_0001, 32'h0000_0000, 8'h80, 32'h8000_0000, 8'hB0};
        tbl[4]  = '{4, 4'hB, 32'h8000_0000, 32'h0000_0000, 8'h00, 32'h0000_0001, 8'h90};
        tbl[5]  = '{2, 4'h4, 32'h0000_1234, 32'h0000_1234, 8'h00, 32'h0000_1234, 8'h40};
        tbl[6]  = '{2, 4'h4, 32'h0000_1234, 32'h0000_1234, 8'h08, 32'h0000_1234, 8'h48};
        tbl[7]  = '{1, 4'h0, 32'h0000_007F, 32'h0000_0001, 8'h00, 32'h0000_0080, 8'h34};
        tbl[8]  = '{1, 4'hF, 32'h0000_0081, 32'h0000_0000, 8'h00, 32'h0000_00C0, 8'hA0};
        tbl[9]  = '{2, 4'h8, 32'h0000_FFFF, 32'h0000_0000, 8'h00, 32'h0000_0000, 8'h40};
        tbl[10] = '{2, 4'h5, 32'h0000_F0F0, 32'h0000_0FFF, 8'hFF, 32'h0000_00F0, 8'h8F};
        tbl[11] = '{2, 4'hD, 32'h0000_0001, 32'h0000_0000, 8'h00, 32'h0000_8000, 8'hB0};
        tbl[12] = '{2, 4'h2, 32'h0000_0100, 32'h0000_0001, 8'h00, 32'h0000_00FF, 8'h08};
        tbl[13] = '{4, 4'h1, 32'h7FFF_FFFF, 32'h0000_0000, 8'h80, 32'h8000_0000, 8'h34};

        reset = 1'b1;
        st1 = 1'b0; st2 = 1'b0; st4 = 1'b0;
        md1 = 4'h0; md2 = 4'h0; md4 = 4'h0;
        a1 = '0; a2 = '0; a4 = '0; b1 = '0; b2 = '0; b4 = '0;
        f1 = '0; f2 = '0; f4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'({bz1, bz2, bz4}), 64'd0);
        chk("rst_done", 64'({dn1, dn2, dn4}), 64'd0);
        chk("rst_out4", 64'(o4), 64'd0);
        chk("rst_flags", 64'({of1, of2, of4}), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].m, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].f);
            case (tbl[i].nb)
                1:       begin got_o = 64'(o1); got_f = of1; end
                2:       begin got_o = 64'(o2); got_f = of2; end
                default: begin got_o = 64'(o4); got_f = of4; end
            endcase
            chk($sformatf("vec%0d_out", i), got_o, 64'(tbl[i].eo));
            chk($sformatf("vec%0d_flags", i), 64'(got_f), 64'(tbl[i].ef));
        end

        // CP with a start held through RUN (ignored), then a start in the DONE cycle (accepted).
        @(posedge clk); #1;
        md2 = 4'h4; a2 = 16'h1234; b2 = 16'h1234; f2 = 8'h00; st2 = 1'b1;
        @(posedge clk); #1;
        md2 = 4'h0; a2 = 16'h0001; b2 = 16'h0001;
        @(posedge clk); #1;
        st2 = 1'b0;
        chk("ign_busy", 64'(bz2), 64'd1);
        chk("ign_no_early_done", 64'(dn2), 64'd0);
        @(posedge clk); #1;
        chk("cp_done", 64'(dn2), 64'd1);
        chk("cp_busy_low", 64'(bz2), 64'd0);
        chk("cp_out", 64'(o2), 64'h1234);
        chk("cp_flags", 64'(of2), 64'h40);
        md2 = 4'h0; a2 = 16'h00FF; b2 = 16'h0001; f2 = 8'h00; st2 = 1'b1;
        @(posedge clk); #1;
        st2 = 1'b0;
        chk("b2b_busy", 64'(bz2), 64'd1);
        chk("b2b_done_c1", 64'(dn2), 64'd0);
        @(posedge clk); #1;
        chk("b2b_done_c2", 64'(dn2), 64'd0);
        chk("b2b_hold_out", 64'(o2), 64'h1234);
        @(posedge clk); #1;
        chk("b2b_done_c3", 64'(dn2), 64'd1);
        chk("b2b_out", 64'(o2), 64'h0100);
        chk("b2b_flags", 64'(of2), 64'h00);
        @(posedge clk); #1;
        chk("b2b_done_pulse", 64'({dn2, bz2}), 64'd0);

        // Reset in the second RUN cycle aborts with no done and clears the held result.
        md2 = 4'h0; a2 = 16'hFFFF; b2 = 16'h0001; f2 = 8'h00; st2 = 1'b1;
        @(posedge clk); #1;
        st2 = 1'b0;
        @(posedge clk); #1;
        chk("abort_mid_busy", 64'(bz2), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 64'(bz2), 64'd0);
        chk("abort_done", 64'(dn2), 64'd0);
        chk("abort_out", 64'(o2), 64'd0);
        chk("abort_flags", 64'(of2), 64'd0);
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (dn2) saw = 1'b1;
        end
        chk("abort_no_done", 64'(saw), 64'd0);

        // Reset wins over a simultaneous start.
        md2 = 4'h0; a2 = 16'h0001; b2 = 16'h0001; st2 = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; st2 = 1'b0;
        chk("rst_vs_start_busy", 64'(bz2), 64'd0);
        @(posedge clk); #1;
        chk("rst_vs_start_idle", 64'({bz2, dn2}), 64'd0);

        // Random sweep, every mode many times, all three word widths against the model.
        for (int i = 0; i < 192; i++) begin
            mv = 4'(i % 16);
            av = {$urandom, $urandom};
            bv = (i % 5 == 0) ? av : {$urandom, $urandom};
            if (i % 7 == 0) av = 64'hFFFF_FFFF_FFFF_FFFF;
            fv = 8'($urandom);
            run_op(mv, av, bv, fv);
            model(1, mv, av, bv, fv, exp_o, exp_f);
            chk($sformatf("rnd%0d_m%h_b1_out", i, mv), 64'(o1), exp_o);
            chk($sformatf("rnd%0d_m%h_b1_flags", i, mv), 64'(of1), 64'(exp_f));
            model(2, mv, av, bv, fv, exp_o, exp_f);
            chk($sformatf("rnd%0d_m%h_b2_out", i, mv), 64'(o2), exp_o);
            chk($sformatf("rnd%0d_m%h_b2_flags", i, mv), 64'(of2), 64'(exp_f));
            model(4, mv, av, bv, fv, exp_o, exp_f);
            chk($sformatf("rnd%0d_m%h_b4_out", i, mv), 64'(o4), exp_o);
            chk($sformatf("rnd%0d_m%h_b4_flags", i, mv), 64'(of4), 64'(exp_f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
